// File: rtl/nco_clk_enable_gen_if.sv
// rtl/nco_clk_enable_gen_if.sv - configuration and tick/square-wave bundle for the NCO enable generator
interface nco_clk_enable_gen_if #(
    parameter int NUM_CH = 4,
    parameter int ACC_W  = 32,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic              cfg_wr;
    logic [CH_W-1:0]   cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] sq_out;
    logic              locked;

    modport master (
        output cfg_wr, cfg_ch, cfg_inc, ch_en,
        input  tick, sq_out, locked
    );

    modport slave (
        input  cfg_wr, cfg_ch, cfg_inc, ch_en,
        output tick, sq_out, locked
    );
endinterface

// File: rtl/nco_clk_enable_gen.sv
// rtl/nco_clk_enable_gen.sv - multi-channel phase-accumulator tick/square-wave enable generator
module nco_clk_enable_gen #(
    parameter int                       NUM_CH      = 4,
    parameter int                       ACC_W       = 32,
    parameter logic [NUM_CH*ACC_W-1:0]  INC_INIT    = {NUM_CH{{{(ACC_W-1){1'b0}}, 1'b1}}},
    parameter int                       LOCK_CYCLES = 16
) (
    input  logic                  refclk,
    input  logic                  rst,
    nco_clk_enable_gen_if.slave   bus
);
    localparam int                CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int                CNT_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [CH_W:0]     NUM_CH_L = (CH_W + 1)'(NUM_CH);
    localparam logic [CNT_W-1:0]  LOCK_CNT = CNT_W'(LOCK_CYCLES);

    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [ACC_W-1:0]  acc_d [NUM_CH];
    logic [ACC_W-1:0]  inc_q [NUM_CH];
    logic [ACC_W-1:0]  inc_d [NUM_CH];
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] sq_q, sq_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              locked_q, locked_d;
    logic              cfg_valid;

    // Writes to a non-existent channel are dropped and must not disturb the lock counter.
    assign cfg_valid = bus.cfg_wr && ({1'b0, bus.cfg_ch} < NUM_CH_L);

    always_comb begin
        tick_d = '0;
        sq_d   = sq_q;
        for (int i = 0; i < NUM_CH; i++) begin
            logic [ACC_W:0] sum;
            sum      = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
            acc_d[i] = acc_q[i];
            inc_d[i] = inc_q[i];
            if (cfg_valid && (bus.cfg_ch == CH_W'(i))) begin
                inc_d[i] = bus.cfg_inc;
                acc_d[i] = '0;
                sq_d[i]  = 1'b0;
            end else if (bus.ch_en[i]) begin
                acc_d[i]  = sum[ACC_W-1:0];
                tick_d[i] = sum[ACC_W] & locked_q;
                if (tick_d[i]) begin
                    sq_d[i] = ~sq_q[i];
                end
            end
        end

        cnt_d = cnt_q;
        if (cfg_valid) begin
            cnt_d = '0;
        end else if (cnt_q != LOCK_CNT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        locked_d = (cnt_d == LOCK_CNT) && !cfg_valid;
    end

    always_ff @(posedge refclk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                inc_q[i] <= INC_INIT[i*ACC_W +: ACC_W];
            end
            tick_q   <= '0;
            sq_q     <= '0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= acc_d[i];
                inc_q[i] <= inc_d[i];
            end
            tick_q   <= tick_d;
            sq_q     <= sq_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

    assign bus.tick   = tick_q;
    assign bus.sq_out = sq_q;
    assign bus.locked = locked_q;
endmodule

// File: tb/tb_nco_clk_enable_gen.sv
// tb/tb_nco_clk_enable_gen.sv - scoreboard bench for nco_clk_enable_gen
module tb_nco_clk_enable_gen;
    localparam int NCH = 3;
    localparam int AW  = 8;
    localparam int LC  = 4;
    localparam int MOD = 256;

    typedef struct packed {
        logic [NCH-1:0] tick;
        logic [NCH-1:0] sq;
        logic           locked;
    } exp_t;

    logic refclk = 1'b0;
    logic rst;
    always #5 refclk = ~refclk;

    nco_clk_enable_gen_if #(.NUM_CH(NCH), .ACC_W(AW)) bus ();

    nco_clk_enable_gen #(.NUM_CH(NCH), .ACC_W(AW), .LOCK_CYCLES(LC)) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus)
    );

    exp_t           exp_q[$];
    int             checks   = 0;
    int             failures = 0;
    int             tick_cnt [NCH];
    int             m_acc [NCH];
    int             m_inc [NCH];
    logic [NCH-1:0] m_tick;
    logic [NCH-1:0] m_sq;
    logic           m_locked;
    int             m_cnt;

    // Reference behaviour applied at each rising edge with the inputs present before it.
    task automatic model_edge();
        int   s;
        bit   valid;
        logic old_locked;
        exp_t e;
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_acc[i] = 0;
                m_inc[i] = 1;
            end
            m_tick = '0; m_sq = '0; m_locked = 1'b0; m_cnt = 0;
        end else begin
            valid      = bus.cfg_wr && (int'(bus.cfg_ch) < NCH);
            old_locked = m_locked;
            for (int i = 0; i < NCH; i++) begin
                m_tick[i] = 1'b0;
                if (valid && int'(bus.cfg_ch) == i) begin
                    m_inc[i] = int'(bus.cfg_inc);
                    m_acc[i] = 0;
                    m_sq[i]  = 1'b0;
                end else if (bus.ch_en[i]) begin
                    s        = m_acc[i] + m_inc[i];
                    m_acc[i] = s % MOD;
                    if (s >= MOD && old_locked) begin
                        m_tick[i] = 1'b1;
                        m_sq[i]   = ~m_sq[i];
                    end
                end
            end
            if (valid) begin
                m_cnt    = 0;
                m_locked = 1'b0;
            end else begin
                if (m_cnt < LC) m_cnt++;
                m_locked = (m_cnt == LC);
            end
        end
        e.tick = m_tick; e.sq = m_sq; e.locked = m_locked;
        exp_q.push_back(e);
    endtask

    always @(negedge refclk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({bus.tick, bus.sq_out, bus.locked} !== e) begin
                failures++;
                $display("FAIL outputs t=%0t actual tick=%b sq=%b locked=%b required tick=%b sq=%b locked=%b",
                         $time, bus.tick, bus.sq_out, bus.locked, e.tick, e.sq, e.locked);
            end
            for (int i = 0; i < NCH; i++) begin
                if (bus.tick[i] === 1'b1) tick_cnt[i]++;
            end
        end
    end

    task automatic step();
        @(posedge refclk);
        model_edge();
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input int ch, input int inc);
        bus.cfg_wr  = 1'b1;
        bus.cfg_ch  = 2'(ch);
        bus.cfg_inc = 8'(inc);
        step();
        bus.cfg_wr  = 1'b0;
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < NCH; i++) tick_cnt[i] = 0;
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    initial begin
        int guard;
        rst = 1'b0;
        bus.cfg_wr = 1'b0; bus.cfg_ch = '0; bus.cfg_inc = '0; bus.ch_en = '0;
        clr_cnt();
        run(2);
        check("reset_outputs", int'({bus.tick, bus.sq_out, bus.locked}), 0);
        rst = 1'b1;

        // inc=64: tick every 4th cycle once locked
        bus.ch_en = 3'b001;
        wr(0, 64);
        run(8);
        check("t1_locked", int'(bus.locked), 1);
        clr_cnt();
        run(32);
        check("t1_ticks_in_32", tick_cnt[0], 8);

        // inc=96: 9 overflows in any 24 consecutive enabled edges
        wr(0, 96);
        run(8);
        clr_cnt();
        run(24);
        check("t2_ticks_in_24", tick_cnt[0], 9);

        // pause ch0 mid-period
        run(2);
        bus.ch_en = 3'b000;
        step();
        clr_cnt();
        run(4);
        check("t3_paused_ticks", tick_cnt[0], 0);
        bus.ch_en = 3'b001;
        run(16);

        // write ch1 exactly on its overflow edge
        bus.ch_en = 3'b011;
        wr(1, 128);
        run(6);
        guard = 0;
        while (m_acc[1] + m_inc[1] < MOD && guard < 4) begin
            step();
            guard++;
        end
        check("t4_found_overflow_edge", int'(m_acc[1] + m_inc[1] >= MOD), 1);
        wr(1, 128);
        check("t4_tick1_suppressed", int'(bus.tick[1]), 0);
        check("t4_locked_dropped", int'(bus.locked), 0);
        run(8);

        // out-of-range channel index is ignored
        check("t5_locked_before", int'(bus.locked), 1);
        wr(3, 200);
        check("t5_locked_kept", int'(bus.locked), 1);
        run(4);

        // inc=0 never ticks, inc=255 ticks back-to-back
        bus.ch_en = 3'b111;
        wr(1, 0);
        wr(2, 255);
        run(12);
        clr_cnt();
        run(16);
        check("bnd_inc0_ticks", tick_cnt[1], 0);
        check("bnd_inc255_ticks", tick_cnt[2], 16);

        // reset wins over a simultaneous write
        bus.cfg_wr = 1'b1; bus.cfg_ch = 2'd0; bus.cfg_inc = 8'd50;
        rst = 1'b0;
        step();
        bus.cfg_wr = 1'b0;
        check("t6_outputs_cleared", int'({bus.tick, bus.sq_out, bus.locked}), 0);
        rst = 1'b1;
        bus.ch_en = 3'b111;
        clr_cnt();
        run(262);
        check("t6_ch0_init_inc", tick_cnt[0], 1);
        check("t6_ch1_init_inc", tick_cnt[1], 1);
        check("t6_ch2_init_inc", tick_cnt[2], 1);

        @(negedge refclk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
